// File: rtl/udp_port_demux.sv
// udp_port_demux
// Receive-side datagram dispatcher. Routes each UDP payload datagram to one
// of NUM_CH application channels by matching its destination port against a
// programmable table. Each channel has a show-ahead FIFO carrying
// {err, last, data}.
//
// Optional feature macro: PORT_DEMUX_DEFAULT_CH_EN
//   defined   - datagrams with no table match go to channel 0; drop_count
//               counts truncations only
//   undefined - datagrams with no table match are dropped and counted
//
// Ports:
//   clk, reset       single clock, asynchronous active-high reset
//   in_valid/in_data payload word stream, contiguous per datagram
//   in_port          destination port, sampled on the first word
//   cfg_we/cfg_ch/cfg_port/cfg_en  port table write
//   out_valid/out_data/out_last/out_err  per-channel FIFO head (zero when empty)
//   out_ready        per-channel pop
//   drop_count       saturating dropped/truncated datagram counter

module udp_port_demux #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    input  logic [15:0]            in_port,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [15:0]            cfg_port,
    input  logic                   cfg_en,
    output logic [NUM_CH-1:0]      out_valid,
    output logic [32*NUM_CH-1:0]   out_data,
    output logic [NUM_CH-1:0]      out_last,
    output logic [NUM_CH-1:0]      out_err,
    input  logic [NUM_CH-1:0]      out_ready,
    output logic [15:0]            drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    // A non-final write that would leave only the reserved slot free is
    // turned into the truncation terminator, so every queued datagram ends
    // with a last=1 entry.
    localparam logic [PW-1:0] TRUNC_THR = PW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Port table
    logic             r_tbl_en   [NUM_CH];
    logic [15:0]      r_tbl_port [NUM_CH];

    // Datapath / FSM state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CH_W-1:0]  r_ch;
    logic [31:0]      r_hold;
    logic [15:0]      r_drop_cnt;

    // Routing decision for the current in_port
    logic             w_route_ok;
    logic [CH_W-1:0]  w_route_ch;
    logic             w_hit;
    logic [CH_W-1:0]  w_hit_ch;

    // FSM controls
    logic             w_wr_req;
    logic             w_wr_last;
    logic             w_wr_err;
    logic             w_hold_ld;
    logic             w_ch_ld;
    logic             w_drop_inc;
    logic [PW-1:0]    w_cur_count;

    // Channel FIFOs: {err, last, data}
    logic [33:0]      r_mem    [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr [NUM_CH];
    logic [PW-1:0]    r_rd_ptr [NUM_CH];
    logic [PW-1:0]    w_count  [NUM_CH];
    logic             w_full   [NUM_CH];
    logic             w_empty  [NUM_CH];
    logic             w_push   [NUM_CH];
    logic             w_pop    [NUM_CH];

    // Port table writes; out-of-range cfg_ch matches no entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_tbl_en[i]   <= 1'b0;
                r_tbl_port[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    r_tbl_en[i]   <= cfg_en;
                    r_tbl_port[i] <= cfg_port;
                end
            end
        end
    end

    // Lowest-index enabled match wins (descending scan, last assignment wins)
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (r_tbl_en[i] && (r_tbl_port[i] == in_port)) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_W'(i);
            end
        end
`ifdef PORT_DEMUX_DEFAULT_CH_EN
        w_route_ok = 1'b1;
        w_route_ch = w_hit ? w_hit_ch : '0;
`else
        w_route_ok = w_hit;
        w_route_ch = w_hit_ch;
`endif
    end

    // Occupancy of the latched target channel
    always_comb begin
        w_cur_count = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (r_ch == CH_W'(i)) begin
                w_cur_count = w_count[i];
            end
        end
    end

    // FSM next-state and controls
    always_comb begin
        w_state_nxt = r_state;
        w_wr_req    = 1'b0;
        w_wr_last   = 1'b0;
        w_wr_err    = 1'b0;
        w_hold_ld   = 1'b0;
        w_ch_ld     = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_route_ok) begin
                        w_state_nxt = S_PASS;
                        w_hold_ld   = 1'b1;
                        w_ch_ld     = 1'b1;
                    end else begin
                        w_state_nxt = S_DROP;
                        w_drop_inc  = 1'b1;
                    end
                end
            end
            S_PASS: begin
                w_wr_req = 1'b1;
                if (in_valid) begin
                    if (w_cur_count >= TRUNC_THR) begin
                        w_wr_last   = 1'b1;
                        w_wr_err    = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_hold_ld = 1'b1;
                    end
                end else begin
                    w_wr_last   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (!in_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, routing latch, hold register, drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_hold     <= 32'h0;
            r_drop_cnt <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ch_ld) begin
                r_ch <= w_route_ch;
            end
            if (w_hold_ld) begin
                r_hold <= in_data;
            end
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign drop_count = r_drop_cnt;

    // FIFO status, push/pop qualification and head presentation
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_last  = '0;
        out_err   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_count[i] = r_wr_ptr[i] - r_rd_ptr[i];
            w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
            w_full[i]  = (r_wr_ptr[i][AW] != r_rd_ptr[i][AW]) &&
                         (r_wr_ptr[i][AW-1:0] == r_rd_ptr[i][AW-1:0]);
            // A write into a full FIFO is discarded so queued entries survive
            w_push[i]  = w_wr_req && (r_ch == CH_W'(i)) && !w_full[i];
            w_pop[i]   = !w_empty[i] && out_ready[i];
            if (!w_empty[i]) begin
                out_valid[i]       = 1'b1;
                out_data[32*i +: 32] = r_mem[i][r_rd_ptr[i][AW-1:0]][31:0];
                out_last[i]        = r_mem[i][r_rd_ptr[i][AW-1:0]][32];
                out_err[i]         = r_mem[i][r_rd_ptr[i][AW-1:0]][33];
            end
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    // FIFO storage (contents are masked at the output while empty)
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i][AW-1:0]] <= {w_wr_err, w_wr_last, r_hold};
            end
        end
    end

endmodule
